// File: rtl/stopwatch_display_if.sv
// rtl/stopwatch_display_if.sv - time inputs and display outputs of the stopwatch display
interface stopwatch_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj_minutes;
    logic       adj_seconds;
    logic [3:0] an;
    logic [7:0] seg;

    modport master (
        output minutes, seconds, adj_minutes, adj_seconds,
        input  an, seg
    );

    modport slave (
        input  minutes, seconds, adj_minutes, adj_seconds,
        output an, seg
    );
endinterface

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - multiplexed MM.SS 7-segment driver with frame snapshot and field blink
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input logic                clk,
    input logic                rst,
    stopwatch_display_if.slave bus
);
    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [5:0]    snap_min;
    logic [5:0]    snap_sec;

    logic          scan_wrap;
    logic          adj_any;
    logic [5:0]    field;
    logic [5:0]    tens;
    logic [5:0]    ones;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    glyph;
    logic [3:0]    an_next;
    logic [7:0]    seg_next;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign adj_any   = bus.adj_minutes | bus.adj_seconds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            snap_min <= 6'd0;
            snap_sec <= 6'd0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) begin
                idx <= idx + 2'd1;
                // Frame boundary: latch a coherent minutes/seconds pair.
                if (idx == 2'd3) begin
                    snap_min <= bus.minutes;
                    snap_sec <= bus.seconds;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!adj_any) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        field = idx[1] ? snap_min : snap_sec;
        tens  = field / 6'd10;
        ones  = field % 6'd10;
        digit = idx[0] ? tens[3:0] : ones[3:0];
        glyph = (field >= 6'd60) ? 7'h3F : decode(digit);
        // Minutes take blink priority when both fields are flagged.
        blank = blink_phase &
                ((bus.adj_minutes & idx[1]) |
                 (~bus.adj_minutes & bus.adj_seconds & ~idx[1]));
        if (blank) begin
            an_next  = 4'hF;
            seg_next = 8'hFF;
        end else begin
            an_next  = ~(4'b0001 << idx);
            seg_next = {(idx != 2'd2), glyph};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= 4'hF;
            bus.seg <= 8'hFF;
        end else begin
            bus.an  <= an_next;
            bus.seg <= seg_next;
        end
    end
endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - randomized model-checked bench for stopwatch_display
module tb_stopwatch_display;
    localparam int SD = 4;
    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_display_if sw_if ();

    stopwatch_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    always #5 clk = ~clk;

    // Reference: time since reset determines digit slot, adj run length determines blink.
    int         m_k;
    int         m_run;
    int         m_min;
    int         m_sec;
    logic [3:0] exp_an  = 4'hF;
    logic [7:0] exp_seg = 8'hFF;

    function automatic logic [11:0] model_out(input int k, input int run, input int mn,
                                              input int sc, input logic am, input logic as_);
        logic [7:0] tbl [10];
        int slot, fld, val, phase;
        logic [7:0] s;
        logic [3:0] a;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        slot  = (k / SD) % 4;
        fld   = (slot >= 2) ? mn : sc;
        val   = (slot % 2 == 0) ? fld % 10 : fld / 10;
        s     = (fld >= 60) ? 8'hBF : tbl[val];
        if (slot == 2) s[7] = 1'b0;
        phase = (am || as_) ? (run / BD) % 2 : 0;
        a     = ~(4'b0001 << slot);
        if (phase == 1 && ((am && slot >= 2) || (!am && as_ && slot < 2))) begin
            a = 4'hF;
            s = 8'hFF;
        end
        return {a, s};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k     <= 0;
            m_run   <= 0;
            m_min   <= 0;
            m_sec   <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 8'hFF;
        end else begin
            {exp_an, exp_seg} <= model_out(m_k, m_run, m_min, m_sec,
                                           sw_if.adj_minutes, sw_if.adj_seconds);
            if (m_k % (4 * SD) == 4 * SD - 1) begin
                m_min <= int'(sw_if.minutes);
                m_sec <= int'(sw_if.seconds);
            end
            m_k   <= m_k + 1;
            m_run <= (sw_if.adj_minutes || sw_if.adj_seconds) ? m_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks = checks + 1;
            if (sw_if.an !== exp_an || sw_if.seg !== exp_seg) begin
                errors = errors + 1;
                $display("FAIL model_cmp t=%0t an=%b seg=%h expected an=%b seg=%h",
                         $time, sw_if.an, sw_if.seg, exp_an, exp_seg);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive(input int mn, input int sc, input logic am, input logic as_);
        @(negedge clk);
        #2;
        sw_if.minutes     = 6'(mn);
        sw_if.seconds     = 6'(sc);
        sw_if.adj_minutes = am;
        sw_if.adj_seconds = as_;
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [7:0] s,
                       input logic [3:0] wa, input logic [7:0] ws);
        checks = checks + 1;
        if (a !== wa || s !== ws) begin
            errors = errors + 1;
            $display("FAIL %s an=%b seg=%h expected an=%b seg=%h", name, a, s, wa, ws);
        end
    endtask

    // Wait (bounded) for a given digit enable, then pin its segment pattern.
    task automatic wait_seg(input string name, input logic [3:0] wa, input logic [7:0] ws);
        bit found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            @(negedge clk);
            if (sw_if.an === wa) found = 1'b1;
        end
        if (!found) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout waiting an=%b last an=%b", name, wa, sw_if.an);
        end else begin
            lit(name, sw_if.an, sw_if.seg, wa, ws);
        end
    endtask

    initial begin
        sw_if.minutes     = 6'd0;
        sw_if.seconds     = 6'd0;
        sw_if.adj_minutes = 1'b0;
        sw_if.adj_seconds = 1'b0;
        #1 rst = 1'b1;
        started = 1'b1;
        step(3);
        #2 rst = 1'b0;
        sw_if.minutes = 6'd7;
        sw_if.seconds = 6'd8;
        step(6);

        // Reset mid-scan clears outputs immediately and restarts the frame.
        #2 rst = 1'b1;
        #1 lit("rst_async", sw_if.an, sw_if.seg, 4'hF, 8'hFF);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        lit("first_digit", sw_if.an, sw_if.seg, 4'b1110, 8'hC0);
        wait_seg("first_min_ones", 4'b1011, 8'h40);

        drive(12, 34, 1'b0, 1'b0);
        step(20);
        wait_seg("s_ones_4", 4'b1110, 8'h99);
        wait_seg("s_tens_3", 4'b1101, 8'hB0);
        wait_seg("m_ones_2dp", 4'b1011, 8'h24);
        wait_seg("m_tens_1", 4'b0111, 8'hF9);

        drive(12, 35, 1'b0, 1'b0);
        step(32);
        wait_seg("s_ones_5", 4'b1110, 8'h92);

        drive(59, 59, 1'b0, 1'b0);
        step(20);
        wait_seg("s_ones_9", 4'b1110, 8'h90);
        wait_seg("m_tens_5", 4'b0111, 8'hA4 ^ 8'h36);
        drive(0, 0, 1'b0, 1'b0);
        step(20);
        wait_seg("zero_min_dp", 4'b1011, 8'h40);
        drive(0, 61, 1'b0, 1'b0);
        step(20);
        wait_seg("dash_s_ones", 4'b1110, 8'hBF);
        wait_seg("dash_s_tens", 4'b1101, 8'hBF);

        drive(12, 34, 1'b0, 1'b1);
        step(20);
        wait_seg("blink_off", 4'hF, 8'hFF);
        step(30);
        drive(12, 34, 1'b0, 1'b0);
        step(20);
        drive(12, 34, 1'b1, 1'b1);
        step(10);
        wait_seg("steady_s_ones", 4'b1110, 8'h99);
        step(40);
        drive(12, 34, 1'b0, 1'b1);
        step(24);
        drive(12, 34, 1'b1, 1'b0);
        step(24);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(9) == 0) sw_if.minutes = 6'($urandom_range(59));
            if ($urandom_range(9) == 0)
                sw_if.seconds = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(59));
            if ($urandom_range(39) == 0) sw_if.adj_minutes = ~sw_if.adj_minutes;
            if ($urandom_range(39) == 0) sw_if.adj_seconds = ~sw_if.adj_seconds;
            if ($urandom_range(499) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        step(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
